mac_layer_sequencer: RTL and testbench
======================================

// Module: mac_layer_sequencer
// PURPOSE
//  Sequences one fully-connected layer (Q neurons x D inputs) on the single shared MAC/accumulator datapath.
//  Generates x/weight read addresses, accumulator clear/write strobes and result writes, with a start/done handshake.
//  Sits between the top-level control and the x/w memories plus the MAC datapath; it replaces ad-hoc per-neuron stepping.
// PARAMETERS
//  D    4  inputs per neuron (>=1)
//  Q    3  neurons per layer (>=1)
//  DW   $clog2(D)   (localparam, min 1) x address / input counter width
//  QW   $clog2(Q)   (localparam, min 1) result address / neuron counter width
//  WAW  $clog2(D*Q) (localparam, min 1) weight address width
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous reset, active high
//  st         in   1    start request; sampled only in IDLE
//  mem_vld    in   1    x/w read data valid; sampled only in WAIT
//  busy       out  1    high in every state except IDLE
//  x_rd       out  1    x memory read strobe
//  w_rd       out  1    weight memory read strobe
//  x_addr     out  DW   x address = d_cnt
//  w_addr     out  WAW  weight address = q_cnt*D + d_cnt
//  acc_clear  out  1    clear accumulator (1-cycle pulse)
//  acc_write  out  1    accumulate current x*w (1-cycle pulse)
//  res_write  out  1    store accumulator to result slot (1-cycle pulse)
//  res_addr   out  QW   result slot = q_cnt
//  done       out  1    layer complete (1-cycle pulse)
// BEHAVIOUR
//  - Reset: the synchronous rst puts the FSM in IDLE and sets d_cnt=q_cnt=0, so every output is 0 on the next cycle.
//    rst has priority over every other input, including during a run. A run interrupted by rst is dropped and does not resume.
//  - Outputs are Moore decodes of the state and counter registers only, with no input-to-output combinational path.
//  - FSM:
//    IDLE  -> CLEAR if st, else IDLE.
//    CLEAR: acc_clear=1, d_cnt<=0 -> FETCH.
//    FETCH: x_rd=w_rd=1, addresses valid -> WAIT.
//    WAIT : addresses held, strobes 0; mem_vld=1 -> ACC, else stay in WAIT. There is no timeout.
//    ACC  : acc_write=1; d_cnt==D-1 -> STORE, else d_cnt++ and go to FETCH.
//    STORE: res_write=1, res_addr=q_cnt; q_cnt==Q-1 -> DONE, else q_cnt++ and go to CLEAR.
//    DONE : done=1, q_cnt<=0, d_cnt<=0 -> IDLE.
//  - x_addr and w_addr are driven in FETCH, WAIT and ACC, and are 0 in all other states.
//  - res_addr is driven in STORE only and is 0 in all other states.
//  - Latency with mem_vld high whenever in WAIT: each neuron takes 3*D+2 cycles.
//    If st is high in cycle t, done is high in cycle t+1+Q*(3*D+2).
//  - Each extra WAIT cycle with mem_vld=0 adds exactly one cycle.
//  - st is ignored while busy; no request is queued.
//    st held high through DONE re-launches only after IDLE is reached.
//  - Counters never wrap past D-1 / Q-1. w_addr never exceeds D*Q-1.
//    Arithmetic is unsigned; the w_addr product is truncated to WAW bits, which is always exact.
//  - Edge case D=1: FETCH/WAIT/ACC runs once per neuron.
//  - Edge case Q=1: STORE goes directly to DONE.
// CONFIGURATION
//  MAC_SEQ_ABORT_EN defined:
//    - Adds input abort (1 bit) and output aborted (1 bit).
//    - abort=1 in any state other than IDLE or DONE goes to IDLE on the next edge and clears both counters.
//      No further res_write or done is issued. aborted pulses for 1 cycle in that IDLE cycle.
//    - abort in IDLE or DONE is ignored. rst still takes priority over abort.
//  MAC_SEQ_ABORT_EN undefined: neither port exists and every run completes to DONE.
// TESTING (D=4, Q=3 unless noted)
//  1. rst, then st pulse in cycle 0, mem_vld=1 -> w_addr reads 0..11 in order.
//     res_write at cycles 14, 28, 42 with res_addr 0, 1, 2; done=1 in cycle 43 only; busy=1 for cycles 1-43.
//  2. mem_vld=0 for 5 cycles in the first WAIT -> addresses stay at x=0, w=0 and acc_write is held off.
//     done moves to cycle 48.
//  3. st pulsed at cycle 20 of a run -> no effect on that run.
//     st held high continuously -> next CLEAR occurs 1 cycle after the IDLE that follows DONE.
//  4. rst asserted in ACC of neuron 1 -> next cycle all outputs 0 with busy=0.
//     A new st runs a full 43-cycle layer starting from w_addr=0.
//  5. D=1, Q=1 -> acc_clear, x_rd, acc_write, res_write and done each pulse exactly once; done at cycle 6.
//  6. With MAC_SEQ_ABORT_EN, abort in WAIT of neuron 2 -> aborted=1 for 1 cycle, busy=0, no further res_write.
//     A subsequent st completes normally.

Source files
------------

// File: rtl/mac_layer_sequencer.sv
// rtl/mac_layer_sequencer.sv - sequences one Q x D fully-connected layer on a shared MAC datapath.
// Optional abort port pair enabled by defining MAC_SEQ_ABORT_EN.
module mac_layer_sequencer #(
    parameter int D = 4,
    parameter int Q = 3,
    localparam int DW  = (D > 1) ? $clog2(D) : 1,
    localparam int QW  = (Q > 1) ? $clog2(Q) : 1,
    localparam int WAW = (D * Q > 1) ? $clog2(D * Q) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st,
    input  logic           mem_vld,
`ifdef MAC_SEQ_ABORT_EN
    input  logic           abort,
    output logic           aborted,
`endif
    output logic           busy,
    output logic           x_rd,
    output logic           w_rd,
    output logic [DW-1:0]  x_addr,
    output logic [WAW-1:0] w_addr,
    output logic           acc_clear,
    output logic           acc_write,
    output logic           res_write,
    output logic [QW-1:0]  res_addr,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_ACC,
        S_STORE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] d_cnt;
    logic [QW-1:0] q_cnt;
    logic          d_last;
    logic          q_last;
    logic          addr_phase;
    logic          abort_hit;

    assign d_last = (d_cnt == DW'(D - 1));
    assign q_last = (q_cnt == QW'(Q - 1));

`ifdef MAC_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (st) next_state = S_CLEAR;
            S_CLEAR: next_state = S_FETCH;
            S_FETCH: next_state = S_WAIT;
            S_WAIT:  if (mem_vld) next_state = S_ACC;
            S_ACC:   next_state = d_last ? S_STORE : S_FETCH;
            S_STORE: next_state = q_last ? S_DONE : S_CLEAR;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort_hit) next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            d_cnt <= '0;
            q_cnt <= '0;
`ifdef MAC_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            state <= next_state;
`ifdef MAC_SEQ_ABORT_EN
            aborted <= abort_hit;
`endif
            if (abort_hit) begin
                d_cnt <= '0;
                q_cnt <= '0;
            end else begin
                case (state)
                    S_CLEAR: d_cnt <= '0;
                    S_ACC:   if (!d_last) d_cnt <= d_cnt + DW'(1);
                    S_STORE: if (!q_last) q_cnt <= q_cnt + QW'(1);
                    S_DONE: begin
                        d_cnt <= '0;
                        q_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Moore decode: outputs depend only on state and counter registers.
    assign addr_phase = (state == S_FETCH) || (state == S_WAIT) || (state == S_ACC);

    always_comb begin
        busy      = (state != S_IDLE);
        x_rd      = (state == S_FETCH);
        w_rd      = (state == S_FETCH);
        acc_clear = (state == S_CLEAR);
        acc_write = (state == S_ACC);
        res_write = (state == S_STORE);
        done      = (state == S_DONE);
        x_addr    = '0;
        w_addr    = '0;
        res_addr  = '0;
        if (addr_phase) begin
            x_addr = d_cnt;
            w_addr = WAW'(q_cnt) * WAW'(D) + WAW'(d_cnt);
        end
        if (state == S_STORE) res_addr = q_cnt;
    end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// tb/tb_mac_layer_sequencer.sv - self-checking bench for mac_layer_sequencer against an op-list model.
// Exercises abort cases when MAC_SEQ_ABORT_EN is defined.
module tb_mac_layer_sequencer;
    localparam int D   = 4;
    localparam int Q   = 3;
    localparam int DW  = (D > 1) ? $clog2(D) : 1;
    localparam int QW  = (Q > 1) ? $clog2(Q) : 1;
    localparam int WAW = (D * Q > 1) ? $clog2(D * Q) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st = 1'b0;
    logic mem_vld = 1'b0;
    logic busy, x_rd, w_rd, acc_clear, acc_write, res_write, done;
    logic [DW-1:0]  x_addr;
    logic [WAW-1:0] w_addr;
    logic [QW-1:0]  res_addr;
    logic busy1, x_rd1, w_rd1, acc_clear1, acc_write1, res_write1, done1;
    logic [0:0] x_addr1, w_addr1, res_addr1;
`ifdef MAC_SEQ_ABORT_EN
    logic abort = 1'b0;
    logic aborted, aborted1;
`endif

    always #5 clk = ~clk;

    mac_layer_sequencer #(.D(D), .Q(Q)) dut (
        .clk(clk), .rst(rst), .st(st), .mem_vld(mem_vld),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .x_rd(x_rd), .w_rd(w_rd), .x_addr(x_addr), .w_addr(w_addr),
        .acc_clear(acc_clear), .acc_write(acc_write), .res_write(res_write),
        .res_addr(res_addr), .done(done)
    );

    mac_layer_sequencer #(.D(1), .Q(1)) dut1 (
        .clk(clk), .rst(rst), .st(st), .mem_vld(1'b1),
`ifdef MAC_SEQ_ABORT_EN
        .abort(1'b0), .aborted(aborted1),
`endif
        .busy(busy1), .x_rd(x_rd1), .w_rd(w_rd1), .x_addr(x_addr1), .w_addr(w_addr1),
        .acc_clear(acc_clear1), .acc_write(acc_write1), .res_write(res_write1),
        .res_addr(res_addr1), .done(done1)
    );

    // Model: a run is the flat list of steps it must perform; the head is the current step.
    typedef enum int {K_CLEAR, K_FETCH, K_WAIT, K_ACC, K_STORE, K_DONE} kind_t;
    typedef struct {
        kind_t k;
        int    q;
        int    d;
    } op_t;

    op_t ops[$];
    bit  ab_exp = 1'b0;
    int  cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        ab_exp = 1'b0;
        if (rst) begin
            ops.delete();
        end else if (ops.size() == 0) begin
            if (st) begin
                for (int q = 0; q < Q; q++) begin
                    ops.push_back('{K_CLEAR, q, 0});
                    for (int d = 0; d < D; d++) begin
                        ops.push_back('{K_FETCH, q, d});
                        ops.push_back('{K_WAIT, q, d});
                        ops.push_back('{K_ACC, q, d});
                    end
                    ops.push_back('{K_STORE, q, 0});
                end
                ops.push_back('{K_DONE, 0, 0});
            end
`ifdef MAC_SEQ_ABORT_EN
        end else if (abort && ops[0].k != K_DONE) begin
            ops.delete();
            ab_exp = 1'b1;
`endif
        end else if (!(ops[0].k == K_WAIT && !mem_vld)) begin
            void'(ops.pop_front());
        end
    end

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        op_t o;
        v = '0;
        v[24] = ab_exp;
        if (ops.size() > 0) begin
            o = ops[0];
            v[23] = 1'b1;
            case (o.k)
                K_CLEAR: v[20] = 1'b1;
                K_FETCH: begin v[22] = 1'b1; v[21] = 1'b1; end
                K_ACC:   v[19] = 1'b1;
                K_STORE: begin v[18] = 1'b1; v[3:0] = 4'(o.q); end
                K_DONE:  v[17] = 1'b1;
                default: ;
            endcase
            if (o.k == K_FETCH || o.k == K_WAIT || o.k == K_ACC) begin
                v[15:8] = 8'(o.q * D + o.d);
                v[7:4]  = 4'(o.d);
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] act_vec();
        logic [31:0] v;
        v = '0;
`ifdef MAC_SEQ_ABORT_EN
        v[24] = aborted;
`endif
        v[23] = busy; v[22] = x_rd; v[21] = w_rd; v[20] = acc_clear;
        v[19] = acc_write; v[18] = res_write; v[17] = done;
        v[15:8] = 8'(w_addr);
        v[7:4]  = 4'(x_addr);
        v[3:0]  = 4'(res_addr);
        return v;
    endfunction

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    bit chk_en = 1'b0;
    bit st_hold = 1'b0;
    int pulse_rel = -1;
    int abort_rel = -1;
    int mv_mode = 0;
    int rw_log[$], dn_log[$], addr_log[$], clr_log[$], ab_log[$];
    int busy_cnt;
    int n_clr1, n_xrd1, n_acc1, n_rw1, n_done1, done1_rel;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        rw_log.delete(); dn_log.delete(); addr_log.delete(); clr_log.delete(); ab_log.delete();
        busy_cnt = 0;
        n_clr1 = 0; n_xrd1 = 0; n_acc1 = 0; n_rw1 = 0; n_done1 = 0; done1_rel = -1;
    endtask

    task automatic tick();
        int rel;
        @(negedge clk);
        rel = cyc - t0;
        if (chk_en) chk($sformatf("cycle_rel%0d", rel), act_vec(), exp_vec());
        if (res_write) rw_log.push_back(rel);
        if (done) dn_log.push_back(rel);
        if (x_rd) addr_log.push_back(int'(w_addr));
        if (acc_clear) clr_log.push_back(rel);
        if (busy) busy_cnt++;
        if (acc_clear1) n_clr1++;
        if (x_rd1) n_xrd1++;
        if (acc_write1) n_acc1++;
        if (res_write1) n_rw1++;
        if (done1) begin n_done1++; done1_rel = rel; end
`ifdef MAC_SEQ_ABORT_EN
        if (aborted) ab_log.push_back(rel);
        abort = (abort_rel >= 0 && rel == abort_rel);
`endif
        st = st_hold || (pulse_rel >= 0 && rel == pulse_rel);
        case (mv_mode)
            1:       mem_vld = 1'($urandom_range(1, 0));
            2:       mem_vld = !(rel >= 3 && rel <= 7);
            default: mem_vld = 1'b1;
        endcase
    endtask

    task automatic launch();
        t0 = cyc;
        st = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (dn_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(dn_log.size() >= n), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        clear_logs();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("reset_state", act_vec(), 32'h0);

        // Nominal layer plus the D=1/Q=1 instance in lockstep.
        clear_logs(); mv_mode = 0;
        launch();
        wait_done(1, 200);
        chk("rw_count", rw_log.size(), 3);
        if (rw_log.size() == 3) begin
            chk("rw0", rw_log[0], 14); chk("rw1", rw_log[1], 28); chk("rw2", rw_log[2], 42);
        end
        chk("done_rel", dn_log.size() > 0 ? dn_log[0] : -1, 43);
        chk("addr_count", addr_log.size(), 12);
        for (int i = 0; i < addr_log.size(); i++) chk($sformatf("w_addr_seq%0d", i), addr_log[i], i);
        chk("busy_cycles", busy_cnt, 43);
        chk("d1_clear", n_clr1, 1); chk("d1_xrd", n_xrd1, 1); chk("d1_acc", n_acc1, 1);
        chk("d1_rw", n_rw1, 1); chk("d1_done", n_done1, 1); chk("d1_done_rel", done1_rel, 6);

        // Five-cycle hold-off in the first WAIT.
        clear_logs(); mv_mode = 2;
        launch();
        wait_done(1, 200);
        chk("holdoff_done_rel", dn_log.size() > 0 ? dn_log[0] : -1, 48);
        mv_mode = 0;

        // Stray start mid-run has no effect.
        clear_logs(); pulse_rel = 20;
        launch();
        wait_done(1, 200);
        chk("stray_st_done_rel", dn_log[0], 43);
        tick(); tick();
        chk("stray_st_clears", clr_log.size(), 3);
        pulse_rel = -1;

        // Start held high relaunches one cycle after IDLE.
        clear_logs(); st_hold = 1'b1;
        launch();
        for (int k = 0; k < 100 && clr_log.size() < 4; k++) tick();
        st_hold = 1'b0;
        chk("held_st_clear", clr_log.size() >= 4 ? clr_log[3] : -1, 45);
        wait_done(2, 200);
        chk("held_st_done2", dn_log.size() >= 2 ? dn_log[1] : -1, 87);

        // Reset in ACC of neuron 1, then a clean layer.
        clear_logs();
        launch();
        while (cyc - t0 < 18) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_run_reset", act_vec(), 32'h0);
        tick(); tick();
        clear_logs();
        launch();
        wait_done(1, 200);
        chk("post_reset_done", dn_log[0], 43);
        chk("post_reset_addr0", addr_log.size() > 0 ? addr_log[0] : -1, 0);

`ifdef MAC_SEQ_ABORT_EN
        clear_logs(); abort_rel = 31;
        launch();
        for (int k = 0; k < 80; k++) tick();
        abort_rel = -1;
        chk("abort_pulse", ab_log.size() == 1 ? ab_log[0] : -1, 32);
        chk("abort_rw", rw_log.size(), 2);
        chk("abort_no_done", dn_log.size(), 0);
        clear_logs();
        launch();
        wait_done(1, 200);
        chk("after_abort_done", dn_log[0], 43);
`endif

        // Randomized memory latency with stray start pulses.
        for (int r = 0; r < 6; r++) begin
            clear_logs(); mv_mode = 1;
            pulse_rel = int'($urandom_range(40, 5));
            launch();
            wait_done(1, 500);
            chk("rand_done_once", dn_log.size(), 1);
            chk("rand_rw_count", rw_log.size(), 3);
            pulse_rel = -1;
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
